// File: rtl/tile_redraw_ctrl.sv
// Redraw scheduler for a 4x4 sliding-puzzle board: erases each dirty tile, then hands the plot port to a glyph drawer.
// Optional feature macro: DRAW_TIMEOUT_EN (bounds the glyph wait and adds the sticky draw_err output).
module tile_redraw_ctrl #(
    parameter int         TILE_PITCH = 29,
    parameter int         TILE_SIZE  = 28,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] board,
    input  logic        board_load,
    output logic        draw_start,
    output logic [7:0]  draw_x,
    output logic [6:0]  draw_y,
    output logic [3:0]  draw_num,
    input  logic        glyph_plot,
    input  logic [7:0]  glyph_x,
    input  logic [6:0]  glyph_y,
    input  logic [2:0]  glyph_colour,
    input  logic        draw_done,
    output logic        plot,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  state_dbg
`ifdef DRAW_TIMEOUT_EN
    ,
    output logic        draw_err
`endif
);
    localparam int CW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW_REQ, S_DRAW_WAIT, S_COMMIT} state_t;
    state_t r_state, w_next;

    logic [63:0]   r_target, r_shown, w_shown_nxt;
    logic [15:0]   r_force, w_force_nxt, w_dirty, w_dirty_after;
    logic [3:0]    r_idx, r_snap, w_sel;
    logic [7:0]    r_ox, w_ox, w_ex, r_x_hold;
    logic [6:0]    r_oy, w_oy, w_ey, r_y_hold;
    logic [2:0]    r_c_hold;
    logic [CW-1:0] r_cx, r_cy;
    logic          w_erase_last, w_timeout;

    // Dirty set now, and as it will be once the tile in flight commits.
    always_comb begin
        w_shown_nxt                = r_shown;
        w_shown_nxt[4*r_idx +: 4]  = r_snap;
        w_force_nxt                = r_force & ~(16'd1 << r_idx);
        w_dirty                    = '0;
        w_dirty_after              = '0;
        w_sel                      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_dirty[i]       = r_force[i] | (r_target[4*i +: 4] != r_shown[4*i +: 4]);
            w_dirty_after[i] = w_force_nxt[i] | (r_target[4*i +: 4] != w_shown_nxt[4*i +: 4]);
        end
        for (int i = 15; i >= 0; i--) begin
            if (w_dirty[i]) w_sel = 4'(i);
        end
    end

    assign w_ox         = 8'(TILE_PITCH * int'(w_sel[1:0]));
    assign w_oy         = 7'(TILE_PITCH * int'(w_sel[3:2]));
    assign w_ex         = r_ox + 8'(r_cx);
    assign w_ey         = r_oy + 7'(r_cy);
    assign w_erase_last = (r_cx == LAST) && (r_cy == LAST);

`ifdef DRAW_TIMEOUT_EN
    logic [9:0] r_to_cnt;
    logic       r_draw_err;
    assign w_timeout = (r_to_cnt == 10'd1022);
    assign draw_err  = r_draw_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt   <= '0;
            r_draw_err <= 1'b0;
        end else begin
            if (r_state == S_DRAW_WAIT) r_to_cnt <= r_to_cnt + 10'd1;
            else                        r_to_cnt <= '0;
            if (r_state == S_DRAW_WAIT && w_timeout && !draw_done) r_draw_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (|w_dirty) w_next = S_ERASE;
            S_ERASE:     if (w_erase_last) w_next = (r_snap == 4'd0) ? S_COMMIT : S_DRAW_REQ;
            S_DRAW_REQ:  w_next = S_DRAW_WAIT;
            S_DRAW_WAIT: if (draw_done || w_timeout) w_next = S_COMMIT;
            S_COMMIT:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // x/y/colour keep the last pixel driven once the port goes quiet.
    always_comb begin
        plot       = 1'b0;
        x          = r_x_hold;
        y          = r_y_hold;
        colour     = r_c_hold;
        draw_start = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_ERASE: begin
                plot   = 1'b1;
                x      = w_ex;
                y      = w_ey;
                colour = BG_COLOUR;
            end
            S_DRAW_REQ: draw_start = 1'b1;
            S_DRAW_WAIT: begin
                plot   = glyph_plot;
                x      = glyph_x;
                y      = glyph_y;
                colour = glyph_colour;
            end
            S_COMMIT: frame_done = ~|w_dirty_after;
            default: ;
        endcase
    end

    assign busy      = (r_state != S_IDLE) || (|w_dirty);
    assign draw_x    = r_ox;
    assign draw_y    = r_oy;
    assign draw_num  = r_snap;
    assign state_dbg = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_target <= '0;
            r_shown  <= '0;
            r_force  <= 16'hFFFF;
            r_idx    <= '0;
            r_snap   <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x_hold <= '0;
            r_y_hold <= '0;
            r_c_hold <= '0;
        end else begin
            if (board_load) r_target <= board;
            case (r_state)
                S_IDLE: if (|w_dirty) begin
                    r_idx  <= w_sel;
                    r_ox   <= w_ox;
                    r_oy   <= w_oy;
                    r_snap <= r_target[4*w_sel +: 4];
                    r_cx   <= '0;
                    r_cy   <= '0;
                end
                S_ERASE: begin
                    r_x_hold <= w_ex;
                    r_y_hold <= w_ey;
                    r_c_hold <= BG_COLOUR;
                    if (r_cx == LAST) begin
                        r_cx <= '0;
                        r_cy <= r_cy + CW'(1);
                    end else begin
                        r_cx <= r_cx + CW'(1);
                    end
                end
                S_DRAW_WAIT: begin
                    r_x_hold <= glyph_x;
                    r_y_hold <= glyph_y;
                    r_c_hold <= glyph_colour;
                end
                S_COMMIT: begin
                    r_shown <= w_shown_nxt;
                    r_force <= w_force_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_redraw_ctrl.sv
// Scoreboard bench for tile_redraw_ctrl: expected plot/draw_start/frame_done events are queued, a monitor pops them.
module tb_tile_redraw_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] board = '0;
    logic        board_load = 1'b0;
    logic        draw_start;
    logic [7:0]  draw_x;
    logic [6:0]  draw_y;
    logic [3:0]  draw_num;
    logic        glyph_plot = 1'b0;
    logic [7:0]  glyph_x = '0;
    logic [6:0]  glyph_y = '0;
    logic [2:0]  glyph_colour = '0;
    logic        draw_done = 1'b0;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        busy;
    logic        frame_done;
    logic [2:0]  state_dbg;
`ifdef DRAW_TIMEOUT_EN
    logic        draw_err;
`endif

    tile_redraw_ctrl dut (
        .clk(clk), .resetn(resetn), .board(board), .board_load(board_load),
        .draw_start(draw_start), .draw_x(draw_x), .draw_y(draw_y), .draw_num(draw_num),
        .glyph_plot(glyph_plot), .glyph_x(glyph_x), .glyph_y(glyph_y), .glyph_colour(glyph_colour),
        .draw_done(draw_done), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
`ifdef DRAW_TIMEOUT_EN
        , .draw_err(draw_err)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // event = {kind, a, b, c}: kind 1 pixel (x,y,colour), 2 draw_start (x,y,num), 3 frame_done
    localparam int W = 21;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] ev(input logic [1:0] k, input logic [7:0] a,
                                        input logic [6:0] b, input logic [3:0] c);
        return {k, a, b, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_erase(input logic [7:0] ox, input logic [6:0] oy);
        for (int cy = 0; cy < 28; cy++)
            for (int cx = 0; cx < 28; cx++)
                exp_q.push_back(ev(2'd1, ox + 8'(cx), oy + 7'(cy), 4'd0));
    endtask

    task automatic push_draw(input logic [7:0] ox, input logic [6:0] oy, input logic [3:0] num);
        exp_q.push_back(ev(2'd2, ox, oy, num));
    endtask

    task automatic push_glyph(input logic [7:0] gx, input logic [6:0] gy, input logic [2:0] c);
        exp_q.push_back(ev(2'd1, gx, gy, {1'b0, c}));
        exp_q.push_back(ev(2'd1, gx + 8'd1, gy, {1'b0, c}));
    endtask

    task automatic push_frame();
        exp_q.push_back(ev(2'd3, 8'd0, 7'd0, 4'd0));
    endtask

    task automatic mon_pop(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: got %0h expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", name, act, e);
            end
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (plot)       mon_pop("plot", ev(2'd1, x, y, {1'b0, colour}));
            if (draw_start) mon_pop("draw_start", ev(2'd2, draw_x, draw_y, draw_num));
            if (frame_done) mon_pop("frame_done", ev(2'd3, 8'd0, 7'd0, 4'd0));
        end
    end

    // drivers
    task automatic load(input logic [63:0] b);
        @(posedge clk); #1;
        board = b;
        board_load = 1'b1;
        @(posedge clk); #1;
        board_load = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (draw_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL draw_start_timeout: got none expected draw_start");
        end
    endtask

    // glyph drawer: one idle cycle, then two pixels, the second alongside draw_done
    task automatic glyph(input logic [7:0] gx, input logic [6:0] gy, input logic [2:0] c);
        bit ok;
        wait_start(ok);
        if (ok) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            glyph_plot = 1'b1; glyph_x = gx; glyph_y = gy; glyph_colour = c;
            @(posedge clk); #1;
            glyph_x = gx + 8'd1; draw_done = 1'b1;
            @(posedge clk); #1;
            glyph_plot = 1'b0; draw_done = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [63:0] B1  = 64'h0000_0000_0070_0000;
    localparam logic [63:0] B3  = 64'h0009_0000_0070_2000;
    localparam logic [63:0] B4A = 64'h0009_0000_0030_2000;
    localparam logic [63:0] B4B = 64'h0009_0000_0090_2000;

    initial begin
        int busy_seen;
        int plot_seen;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_xyc", {14'd0, x, y, colour}, 32'd0);
        chk("rst_draw_start", 32'(draw_start), 32'd0);
        chk("rst_draw_xyn", {13'd0, draw_x, draw_y, draw_num}, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // power-up: all 16 tiles erased in index order, one frame_done
        for (int i = 0; i < 16; i++) push_erase(8'(29 * (i % 4)), 7'(29 * (i / 4)));
        push_frame();
        mon_en = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("busy_after_reset", 32'(busy), 32'd1);
        wait_idle("powerup");

        // single numbered tile 5
        push_erase(8'd29, 7'd29);
        push_draw(8'd29, 7'd29, 4'd7);
        push_glyph(8'd29, 7'd29, 3'd5);
        push_frame();
        load(B1);
        glyph(8'd29, 7'd29, 3'd5);
        wait_idle("tile5");
        chk("x_hold", 32'(x), 32'd30);

        // two tiles at once: 3 then 12
        push_erase(8'd87, 7'd0);
        push_draw(8'd87, 7'd0, 4'd2);
        push_glyph(8'd100, 7'd5, 3'd2);
        push_erase(8'd0, 7'd87);
        push_draw(8'd0, 7'd87, 4'd9);
        push_glyph(8'd3, 7'd90, 3'd1);
        push_frame();
        load(B3);
        glyph(8'd100, 7'd5, 3'd2);
        glyph(8'd3, 7'd90, 3'd1);
        wait_idle("tiles3_12");

        // reload of tile 5 during its erase: drawn with 3, then redrawn with 9
        push_erase(8'd29, 7'd29);
        push_draw(8'd29, 7'd29, 4'd3);
        push_glyph(8'd40, 7'd40, 3'd3);
        push_erase(8'd29, 7'd29);
        push_draw(8'd29, 7'd29, 4'd9);
        push_glyph(8'd41, 7'd41, 3'd6);
        push_frame();
        load(B4A);
        repeat (100) @(posedge clk);
        load(B4B);
        glyph(8'd40, 7'd40, 3'd3);
        glyph(8'd41, 7'd41, 3'd6);
        wait_idle("reload5");

        // identical board: nothing happens
        busy_seen = 0;
        plot_seen = 0;
        load(B4B);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (plot) plot_seen++;
        end
        chk("same_board_busy", 32'(busy_seen), 32'd0);
        chk("same_board_plot", 32'(plot_seen), 32'd0);

`ifdef DRAW_TIMEOUT_EN
        begin
            bit ok;
            int n;
            chk("draw_err_clear", 32'(draw_err), 32'd0);
            push_erase(8'd0, 7'd0);
            push_draw(8'd0, 7'd0, 4'd1);
            push_erase(8'd29, 7'd0);
            push_draw(8'd29, 7'd0, 4'd4);
            push_glyph(8'd30, 7'd2, 3'd4);
            push_frame();
            load(64'h0009_0000_0090_2041);
            wait_start(ok);
            n = 0;
            if (ok) begin
                do begin
                    @(negedge clk);
                    n++;
                end while (state_dbg != 3'd4 && n < 2000);
            end
            chk("timeout_cycles", 32'(n), 32'd1024);
            chk("draw_err_set", 32'(draw_err), 32'd1);
            glyph(8'd30, 7'd2, 3'd4);
            wait_idle("timeout");
            chk("draw_err_sticky", 32'(draw_err), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
